// File: rtl/i2c_slave_regfile_if.sv
// i2c_slave_regfile_if: pin-level and register-write signals of the I2C target.
//   scl_i, sda_i : bus levels seen at the pins (asynchronous to clk)
//   sda_oe       : 1 = target pulls SDA low
//   wr_strobe    : one-cycle pulse per register written from the bus
//   wr_addr      : register index written, valid with wr_strobe
//   wr_data      : byte written, valid with wr_strobe
//   busy         : target is addressed and engaged in a transfer
interface i2c_slave_regfile_if #(
  parameter int ADDR_W = 4
);
  logic              scl_i;
  logic              sda_i;
  logic              sda_oe;
  logic              wr_strobe;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;

  modport master (
    output scl_i, sda_i,
    input  sda_oe, wr_strobe, wr_addr, wr_data, busy
  );

  modport slave (
    input  scl_i, sda_i,
    output sda_oe, wr_strobe, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C target exposing a 2**ADDR_W x 8 register file with
// an auto-incrementing register pointer. 7-bit addressing, no clock
// stretching. SDA is open-drain: the target only ever pulls low via sda_oe.
//   clk   : system clock (>= 10x SCL)
//   reset : synchronous, active-high
//   bus   : slave modport (scl_i, sda_i in; sda_oe, wr_*, busy out)
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h5D,
  parameter int         ADDR_W     = 4
) (
  input logic                clk,
  input logic                reset,
  i2c_slave_regfile_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK, S_IGNORE
  } state_t;

  // [1:0] synchroniser, [2] history
  logic [2:0] scl_q, sda_q;
  logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  state_t                      state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic [7:0]                  sh_q, sh_d;
  logic [ADDR_W-1:0]           ptr_q, ptr_d;
  logic                        rw_q, rw_d;
  logic                        oe_q, oe_d;
  logic                        busy_q, busy_d;
  logic                        strb_q, strb_d;
  logic [ADDR_W-1:0]           waddr_q, waddr_d;
  logic [7:0]                  wdata_q, wdata_d;
  logic [DEPTH-1:0][7:0]       mem_q;
  logic                        mem_we;
  logic [7:0]                  rx_byte;

  assign scl_s     = scl_q[1];
  assign sda_s     = sda_q[1];
  assign scl_rise  =  scl_s & ~scl_q[2];
  assign scl_fall  = ~scl_s &  scl_q[2];
  // SDA edges only count as START/STOP while SCL is steadily high
  assign start_det = scl_s & scl_q[2] &  sda_q[2] & ~sda_s;
  assign stop_det  = scl_s & scl_q[2] & ~sda_q[2] &  sda_s;
  assign rx_byte   = {sh_q[6:0], sda_s};

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_q   <= 3'b111;
      sda_q   <= 3'b111;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      ptr_q   <= '0;
      rw_q    <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      strb_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      scl_q   <= {scl_q[1:0], bus.scl_i};
      sda_q   <= {sda_q[1:0], bus.sda_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ptr_q   <= ptr_d;
      rw_q    <= rw_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      strb_q  <= strb_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       mem_q        <= '0;
    else if (mem_we) mem_q[ptr_q] <= rx_byte;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ptr_d   = ptr_q;
    rw_d    = rw_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    strb_d  = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    mem_we  = 1'b0;
    // bus conditions override whatever byte is in flight
    if (stop_det) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else if (start_det) begin
      state_d = S_ADDR;
      oe_d    = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_ADDR, S_REG, S_WDATA: begin
          // cnt counts received bits; at 8 the byte is done and we wait
          // for the SCL fall that opens the ACK slot
          if (scl_rise && cnt_q != 4'd8) begin
            sh_d  = rx_byte;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              unique case (state_q)
                S_ADDR: begin
                  if (rx_byte[7:1] == SLAVE_ADDR && rx_byte[7:1] != 7'd0) begin
                    busy_d = 1'b1;
                    rw_d   = rx_byte[0];
                  end else begin
                    state_d = S_IGNORE;
                    busy_d  = 1'b0;
                  end
                end
                S_REG:   ptr_d = rx_byte[ADDR_W-1:0];
                default: begin
                  mem_we  = 1'b1;
                  strb_d  = 1'b1;
                  waddr_d = ptr_q;
                  wdata_d = rx_byte;
                  ptr_d   = ptr_q + 1'b1;
                end
              endcase
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            oe_d  = 1'b1;
            cnt_d = '0;
            unique case (state_q)
              S_ADDR:  state_d = S_ADDR_ACK;
              S_REG:   state_d = S_REG_ACK;
              default: state_d = S_WDATA_ACK;
            endcase
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = '0;
            if (rw_q) begin
              state_d = S_RDATA;
              sh_d    = mem_q[ptr_q];
              oe_d    = ~mem_q[ptr_q][7];
            end else begin
              state_d = S_REG;
              oe_d    = 1'b0;
            end
          end
        end
        S_REG_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            state_d = S_WDATA;
            oe_d    = 1'b0;
            cnt_d   = '0;
          end
        end
        S_RDATA: begin
          // bit7 is already on the line; each fall presents the next bit
          if (scl_fall) begin
            if (cnt_q == 4'd7) begin
              state_d = S_RACK;
              oe_d    = 1'b0;
              cnt_d   = '0;
            end else begin
              oe_d  = ~sh_q[6];
              sh_d  = {sh_q[6:0], 1'b0};
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        S_RACK: begin
          if (scl_rise && cnt_q == 4'd0) begin
            ptr_d = ptr_q + 1'b1;
            if (sda_s) state_d = S_IGNORE;
            else       cnt_d   = 4'd1;
          end else if (scl_fall && cnt_q == 4'd1) begin
            state_d = S_RDATA;
            sh_d    = mem_q[ptr_q];
            oe_d    = ~mem_q[ptr_q][7];
            cnt_d   = '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sda_oe    = oe_q;
  assign bus.wr_strobe = strb_q;
  assign bus.wr_addr   = waddr_q;
  assign bus.wr_data   = wdata_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb_i2c_slave_regfile: bit-banged I2C master driving the target, with a
// flat array model of the register file and pointer.
module tb_i2c_slave_regfile;
  localparam int Q = 50;  // quarter SCL period (ns); clk is 10 ns

  logic clk = 1'b0;
  logic reset;
  logic scl_m, sda_m;
  always #5 clk = ~clk;

  i2c_slave_regfile_if #(.ADDR_W(4)) bus ();
  assign bus.scl_i = scl_m;
  assign bus.sda_i = sda_m & ~bus.sda_oe;  // wired-AND open drain

  i2c_slave_regfile #(.SLAVE_ADDR(7'h5D), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_cmp = 0, n_fail = 0;

  // reference model
  logic [7:0] mem_m [16];
  int         ptr_m;

  // observation
  logic [3:0] strb_a [$];
  logic [7:0] strb_d [$];
  int         oe_cyc = 0, busy_cyc = 0;
  always @(posedge clk) begin
    if (bus.wr_strobe) begin
      strb_a.push_back(bus.wr_addr);
      strb_d.push_back(bus.wr_data);
    end
    if (bus.sda_oe) oe_cyc <= oe_cyc + 1;
    if (bus.busy)   busy_cyc <= busy_cyc + 1;
  end

  // ---------------- bus primitives ----------------
  task automatic i2c_start();
    #Q sda_m = 1'b1;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b0;
    #Q scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    #Q sda_m = 1'b0;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b1;
    #(2*Q);
  endtask

  task automatic write_bit(input logic b);
    #Q sda_m = b;
    #Q scl_m = 1'b1;
    #(2*Q) scl_m = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    #Q sda_m = 1'b1;
    #Q scl_m = 1'b1;
    #Q b = bus.sda_i;
    #Q scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] v, input logic nack, output logic line);
    for (int i = 7; i >= 0; i--) read_bit(v[i]);
    if (nack) read_bit(line);
    else begin
      write_bit(1'b0);
      line = 1'b0;
    end
  endtask

  task automatic xfer_w(input logic [7:0] ab, input logic [7:0] rg,
                        input logic [7:0] d [8], input int n,
                        output int nacks, output logic busy_mid);
    logic a;
    nacks = 0;
    i2c_start();
    write_byte(ab, a); nacks += int'(a);
    write_byte(rg, a); nacks += int'(a);
    for (int i = 0; i < n; i++) begin
      write_byte(d[i], a); nacks += int'(a);
    end
    busy_mid = bus.busy;
    i2c_stop();
  endtask

  task automatic xfer_r(input bit set_ptr, input logic [7:0] rg, input int n,
                        output logic [7:0] q [8], output int nacks,
                        output logic rack_line, output logic oe_after);
    logic a;
    nacks = 0;
    i2c_start();
    if (set_ptr) begin
      write_byte(8'hBA, a); nacks += int'(a);
      write_byte(rg, a);    nacks += int'(a);
      i2c_start();
    end
    write_byte(8'hBB, a); nacks += int'(a);
    for (int i = 0; i < n; i++) read_byte(q[i], (i == n-1), rack_line);
    #(2*Q) oe_after = bus.sda_oe;
    i2c_stop();
  endtask

  // model operations
  task automatic model_write(input logic [7:0] rg, input logic [7:0] d [8], input int n);
    ptr_m = int'(rg) % 16;
    for (int i = 0; i < n; i++) begin
      mem_m[ptr_m] = d[i];
      ptr_m = (ptr_m + 1) % 16;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_cmp++; if (bus.sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe got %b want 0", bus.sda_oe); end
    n_cmp++; if (bus.wr_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_wr_strobe got %b want 0", bus.wr_strobe); end
    n_cmp++; if (bus.wr_addr !== 4'h0) begin n_fail++; $display("FAIL reset_wr_addr got %h want 0", bus.wr_addr); end
    n_cmp++; if (bus.wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data got %h want 00", bus.wr_data); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_write();
    logic [7:0] d [8];
    int nk, s0;
    logic bm;
    d = '{default: 8'h00};
    d[0] = 8'h3A;
    s0 = strb_a.size();
    xfer_w(8'hBA, 8'h01, d, 1, nk, bm);
    model_write(8'h01, d, 1);
    n_cmp++; if (nk !== 0) begin n_fail++; $display("FAIL write_acks got %0d nacks want 0", nk); end
    n_cmp++; if (bm !== 1'b1) begin n_fail++; $display("FAIL write_busy_mid got %b want 1", bm); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_after_stop got %b want 0", bus.busy); end
    n_cmp++; if (strb_a.size() - s0 !== 1) begin n_fail++; $display("FAIL write_strobe_count got %0d want 1", strb_a.size() - s0); end
    else begin
      n_cmp++; if (strb_a[s0] !== 4'h1 || strb_d[s0] !== 8'h3A) begin
        n_fail++; $display("FAIL write_strobe_val got %h/%h want 1/3a", strb_a[s0], strb_d[s0]);
      end
    end
  endtask

  task automatic test_readback();
    logic [7:0] q [8];
    int nk;
    logic rl, oa;
    xfer_r(1'b1, 8'h01, 1, q, nk, rl, oa);
    ptr_m = 2;
    n_cmp++; if (nk !== 0) begin n_fail++; $display("FAIL readback_acks got %0d nacks want 0", nk); end
    n_cmp++; if (q[0] !== 8'h3A) begin n_fail++; $display("FAIL readback_data got %h want 3a", q[0]); end
    n_cmp++; if (rl !== 1'b1) begin n_fail++; $display("FAIL readback_rack_released got %b want 1", rl); end
    n_cmp++; if (oa !== 1'b0) begin n_fail++; $display("FAIL readback_oe_after_nack got %b want 0", oa); end
  endtask

  task automatic test_burst_wrap();
    logic [7:0] d [8];
    logic [7:0] q [8];
    logic [3:0] ea [3];
    int nk, s0;
    logic bm, rl, oa;
    d = '{default: 8'h00};
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    ea[0] = 4'hE; ea[1] = 4'hF; ea[2] = 4'h0;
    s0 = strb_a.size();
    xfer_w(8'hBA, 8'h0E, d, 3, nk, bm);
    model_write(8'h0E, d, 3);
    n_cmp++; if (nk !== 0) begin n_fail++; $display("FAIL burst_acks got %0d nacks want 0", nk); end
    n_cmp++; if (strb_a.size() - s0 !== 3) begin n_fail++; $display("FAIL burst_strobe_count got %0d want 3", strb_a.size() - s0); end
    else for (int i = 0; i < 3; i++) begin
      n_cmp++; if (strb_a[s0+i] !== ea[i] || strb_d[s0+i] !== d[i]) begin
        n_fail++; $display("FAIL burst_strobe%0d got %h/%h want %h/%h", i, strb_a[s0+i], strb_d[s0+i], ea[i], d[i]);
      end
    end
    xfer_r(1'b1, 8'h0E, 3, q, nk, rl, oa);
    ptr_m = 1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (q[i] !== d[i]) begin n_fail++; $display("FAIL burst_read%0d got %h want %h", i, q[i], d[i]); end
    end
  endtask

  task automatic test_mismatch();
    logic [7:0] d [8];
    int nk, s0, oe0, bz0;
    logic bm;
    d = '{default: 8'h00};
    s0 = strb_a.size(); oe0 = oe_cyc; bz0 = busy_cyc;
    xfer_w(8'hB8, 8'h00, d, 0, nk, bm);
    n_cmp++; if (nk !== 2) begin n_fail++; $display("FAIL mismatch_nacks got %0d want 2", nk); end
    n_cmp++; if (oe_cyc !== oe0) begin n_fail++; $display("FAIL mismatch_oe_cycles got %0d want %0d", oe_cyc, oe0); end
    n_cmp++; if (busy_cyc !== bz0) begin n_fail++; $display("FAIL mismatch_busy_cycles got %0d want %0d", busy_cyc, bz0); end
    n_cmp++; if (strb_a.size() !== s0) begin n_fail++; $display("FAIL mismatch_strobes got %0d want %0d", strb_a.size(), s0); end
  endtask

  task automatic test_abort();
    logic [7:0] q [8];
    logic a, rl, oa;
    int s0, nk;
    logic [7:0] exp;
    s0 = strb_a.size();
    i2c_start();
    write_byte(8'hBA, a);
    write_byte(8'h05, a);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    i2c_stop();
    ptr_m = 5;
    n_cmp++; if (strb_a.size() !== s0) begin n_fail++; $display("FAIL abort_strobes got %0d want %0d", strb_a.size(), s0); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", bus.busy); end
    exp = mem_m[5];
    xfer_r(1'b0, 8'h00, 1, q, nk, rl, oa);
    ptr_m = 6;
    n_cmp++; if (nk !== 0 || q[0] !== exp) begin
      n_fail++; $display("FAIL abort_followup got %h nacks %0d want %h nacks 0", q[0], nk, exp);
    end
  endtask

  task automatic test_random();
    logic [7:0] d [8];
    logic [7:0] q [8];
    logic [3:0] ea [8];
    logic [7:0] ed [8];
    int nk, s0, n, p;
    logic bm, rl, oa, sp;
    logic [7:0] rg;
    for (int it = 0; it < 12; it++) begin
      n  = int'($urandom_range(1, 4));
      rg = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        d = '{default: 8'h00};
        for (int i = 0; i < n; i++) d[i] = 8'($urandom_range(0, 255));
        p = int'(rg) % 16;
        for (int i = 0; i < n; i++) begin ea[i] = 4'(p); ed[i] = d[i]; p = (p + 1) % 16; end
        s0 = strb_a.size();
        xfer_w(8'hBA, rg, d, n, nk, bm);
        model_write(rg, d, n);
        n_cmp++; if (nk !== 0) begin n_fail++; $display("FAIL rand_w%0d_acks got %0d want 0", it, nk); end
        n_cmp++; if (strb_a.size() - s0 !== n) begin
          n_fail++; $display("FAIL rand_w%0d_strobes got %0d want %0d", it, strb_a.size() - s0, n);
        end else for (int i = 0; i < n; i++) begin
          n_cmp++; if (strb_a[s0+i] !== ea[i] || strb_d[s0+i] !== ed[i]) begin
            n_fail++; $display("FAIL rand_w%0d_strobe%0d got %h/%h want %h/%h", it, i, strb_a[s0+i], strb_d[s0+i], ea[i], ed[i]);
          end
        end
      end else begin
        sp = 1'($urandom_range(0, 1));
        if (sp) ptr_m = int'(rg) % 16;
        for (int i = 0; i < n; i++) begin ed[i] = mem_m[ptr_m]; ptr_m = (ptr_m + 1) % 16; end
        xfer_r(sp, rg, n, q, nk, rl, oa);
        n_cmp++; if (nk !== 0) begin n_fail++; $display("FAIL rand_r%0d_acks got %0d want 0", it, nk); end
        for (int i = 0; i < n; i++) begin
          n_cmp++; if (q[i] !== ed[i]) begin n_fail++; $display("FAIL rand_r%0d_byte%0d got %h want %h", it, i, q[i], ed[i]); end
        end
      end
    end
  endtask

  task automatic test_reset_midread();
    logic [7:0] d [8];
    logic [7:0] q [8];
    int nk;
    logic a, bm, rl, oa;
    d = '{default: 8'h00};
    d[0] = 8'h15;  // bit7 = 0, so the target pulls SDA for the first read bit
    xfer_w(8'hBA, 8'h02, d, 1, nk, bm);
    i2c_start();
    write_byte(8'hBA, a);
    write_byte(8'h02, a);
    i2c_start();
    write_byte(8'hBB, a);
    #(6*10);
    n_cmp++; if (bus.sda_oe !== 1'b1) begin n_fail++; $display("FAIL midread_driving got %b want 1", bus.sda_oe); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.sda_oe !== 1'b0) begin n_fail++; $display("FAIL midread_reset_release got %b want 0", bus.sda_oe); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    i2c_stop();
    for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
    ptr_m = 0;
    // read all 16 registers from the reset pointer without a REG phase
    for (int k = 0; k < 2; k++) begin
      xfer_r(1'b0, 8'h00, 8, q, nk, rl, oa);
      for (int i = 0; i < 8; i++) begin
        n_cmp++; if (q[i] !== mem_m[ptr_m]) begin n_fail++; $display("FAIL midread_cleared reg%0d got %h want %h", ptr_m, q[i], mem_m[ptr_m]); end
        ptr_m = (ptr_m + 1) % 16;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
    ptr_m = 0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    test_reset();
    test_write();
    test_readback();
    test_burst_wrap();
    test_mismatch();
    test_abort();
    test_random();
    test_reset_midread();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
